// File: rtl/tour_cmd_seq_pkg.sv
// Shared constants and types for the knight's-tour command sequencer.
package tour_cmd_seq_pkg;

  localparam int unsigned NUM_MOVES = 24;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned CMD_W     = 16;
  localparam int unsigned RESP_W    = 8;
  localparam int unsigned HDG_W     = 8;
  localparam int unsigned SQ_W      = 4;

  localparam logic [3:0] OPC_MOVE    = 4'b0010;
  localparam logic [3:0] OPC_MOVE_FF = 4'b0011;

  localparam logic [HDG_W-1:0] HDG_N = 8'h00;
  localparam logic [HDG_W-1:0] HDG_W_ = 8'h3F;
  localparam logic [HDG_W-1:0] HDG_S = 8'h7F;
  localparam logic [HDG_W-1:0] HDG_E = 8'hBF;

  localparam logic [RESP_W-1:0] RESP_INT  = 8'hA5;
  localparam logic [RESP_W-1:0] RESP_DONE = 8'h5A;

  // Bit position of each L-move in the one-hot move byte, named by (dx,dy).
  typedef enum logic [2:0] {
    MV_P1_P2 = 3'd0,
    MV_M1_P2 = 3'd1,
    MV_M2_P1 = 3'd2,
    MV_M2_M1 = 3'd3,
    MV_M1_M2 = 3'd4,
    MV_P1_M2 = 3'd5,
    MV_P2_M1 = 3'd6,
    MV_P2_P1 = 3'd7
  } mv_bit_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    HOLD_V = 3'd2,
    HORZ   = 3'd3,
    HOLD_H = 3'd4
  } state_e;

endpackage

// File: rtl/tour_cmd_seq_if.sv
// Command/response bus between UART wrapper, sequencer and cmd_proc.
// slave  : sequencer side (drives cmd, cmd_rdy, clr_cmd_rdy_UART, resp)
// master : environment side (UART wrapper + cmd_proc)
interface tour_cmd_seq_if;
  import tour_cmd_seq_pkg::*;

  logic [CMD_W-1:0]  cmd_UART;
  logic              cmd_rdy_UART;
  logic              clr_cmd_rdy_UART;
  logic [CMD_W-1:0]  cmd;
  logic              cmd_rdy;
  logic              clr_cmd_rdy;
  logic              send_resp;
  logic [RESP_W-1:0] resp;

  modport slave (
    input  cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    output cmd, cmd_rdy, clr_cmd_rdy_UART, resp
  );

  modport master (
    output cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
    input  cmd, cmd_rdy, clr_cmd_rdy_UART, resp
  );
endinterface

// File: rtl/tour_cmd_seq_mv_decode.sv
// Decodes a one-hot knight move into vertical/horizontal heading and
// square counts. Combinational.
// move    : one-hot L-move
// hdg_v/sq_v, hdg_h/sq_h : heading and distance of each half
// illegal : move is zero or has more than one bit set
module tour_cmd_seq_mv_decode
  import tour_cmd_seq_pkg::*;
(
  input  logic [7:0]       move,
  output logic [HDG_W-1:0] hdg_v,
  output logic [SQ_W-1:0]  sq_v,
  output logic [HDG_W-1:0] hdg_h,
  output logic [SQ_W-1:0]  sq_h,
  output logic             illegal
);

  logic signed [2:0] dx;
  logic signed [2:0] dy;
  logic [2:0]        ax;
  logic [2:0]        ay;

  always_comb begin
    dx = 3'sd0;
    dy = 3'sd0;
    // Exactly one bit set <=> nonzero and clearing the lowest set bit leaves zero.
    illegal = (move == 8'd0) || ((move & (move - 8'd1)) != 8'd0);
    if      (move[MV_P1_P2]) begin dx =  3'sd1; dy =  3'sd2; end
    else if (move[MV_M1_P2]) begin dx = -3'sd1; dy =  3'sd2; end
    else if (move[MV_M2_P1]) begin dx = -3'sd2; dy =  3'sd1; end
    else if (move[MV_M2_M1]) begin dx = -3'sd2; dy = -3'sd1; end
    else if (move[MV_M1_M2]) begin dx = -3'sd1; dy = -3'sd2; end
    else if (move[MV_P1_M2]) begin dx =  3'sd1; dy = -3'sd2; end
    else if (move[MV_P2_M1]) begin dx =  3'sd2; dy = -3'sd1; end
    else if (move[MV_P2_P1]) begin dx =  3'sd2; dy =  3'sd1; end
    ax = dx[2] ? unsigned'(-dx) : unsigned'(dx);
    ay = dy[2] ? unsigned'(-dy) : unsigned'(dy);
    sq_v  = {1'b0, ay};
    sq_h  = {1'b0, ax};
    hdg_v = dy[2] ? HDG_S : HDG_N;
    hdg_h = dx[2] ? HDG_W_ : HDG_E;
  end

endmodule

// File: rtl/tour_cmd_seq.sv
// Command sequencer: passes UART commands to cmd_proc while idle, and
// after start_tour replays the solved tour as vertical + horizontal
// (fanfare) move pairs, selecting the BLE response byte.
// clk, rst   : clock, synchronous active-high reset
// start_tour : pulse, begin replaying the solution
// move       : one-hot move for mv_indx (combinational lookup upstream)
// mv_indx    : index of the move being replayed
// bus        : UART / cmd_proc command and response signals
module tour_cmd_seq
  import tour_cmd_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start_tour,
  input  logic [7:0]       move,
  output logic [IDX_W-1:0] mv_indx,
  tour_cmd_seq_if.slave    bus
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   mv_indx_q, mv_indx_d;
  logic [RESP_W-1:0]  resp_q, resp_d;
  logic [7:0]         move_q, move_d;
  logic [7:0]         dec_move;
  logic [HDG_W-1:0]   hdg_v, hdg_h;
  logic [SQ_W-1:0]    sq_v, sq_h;
  logic               illegal;
  logic [CMD_W-1:0]   cmd_c;
  logic               cmd_rdy_c;
  logic               clr_uart_c;
  logic               last_move;

  // In VERT mv_indx is already updated, so decode the live lookup; later
  // states use the copy captured while in VERT.
  assign dec_move  = (state_q == VERT) ? move : move_q;
  assign last_move = (mv_indx_q == IDX_W'(NUM_MOVES - 1));

  tour_cmd_seq_mv_decode u_dec (
    .move    (dec_move),
    .hdg_v   (hdg_v),
    .sq_v    (sq_v),
    .hdg_h   (hdg_h),
    .sq_h    (sq_h),
    .illegal (illegal)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
      resp_q    <= RESP_DONE;
      move_q    <= '0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
      resp_q    <= resp_d;
      move_q    <= move_d;
    end
  end

  // Next-state and bus outputs.
  always_comb begin
    state_d    = state_q;
    mv_indx_d  = mv_indx_q;
    resp_d     = resp_q;
    move_d     = move_q;
    cmd_c      = {OPC_MOVE, hdg_v, sq_v};
    cmd_rdy_c  = 1'b0;
    clr_uart_c = 1'b0;

    case (state_q)
      IDLE: begin
        // start_tour wins over a coincident UART command, which stays pending.
        cmd_c      = bus.cmd_UART;
        cmd_rdy_c  = bus.cmd_rdy_UART & ~start_tour;
        clr_uart_c = bus.clr_cmd_rdy & ~start_tour;
        if (start_tour) begin
          state_d   = VERT;
          mv_indx_d = '0;
          resp_d    = RESP_INT;
        end
      end
      VERT: begin
        move_d = move;
        if (illegal) begin
          state_d = IDLE;
          resp_d  = RESP_DONE;
        end else begin
          cmd_rdy_c = 1'b1;
          if (bus.clr_cmd_rdy) state_d = HOLD_V;
        end
      end
      HOLD_V: begin
        if (bus.send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd_c     = {OPC_MOVE_FF, hdg_h, sq_h};
        cmd_rdy_c = 1'b1;
        if (bus.clr_cmd_rdy) begin
          state_d = HOLD_H;
          // Final half-move answers with the completion byte.
          resp_d  = last_move ? RESP_DONE : RESP_INT;
        end
      end
      HOLD_H: begin
        cmd_c = {OPC_MOVE_FF, hdg_h, sq_h};
        if (bus.send_resp) begin
          if (last_move) begin
            state_d = IDLE;
            resp_d  = RESP_DONE;
          end else begin
            state_d   = VERT;
            mv_indx_d = mv_indx_q + IDX_W'(1);
            resp_d    = RESP_INT;
          end
        end
      end
      default: begin
        state_d = IDLE;
        resp_d  = RESP_DONE;
      end
    endcase
  end

  assign bus.cmd              = cmd_c;
  assign bus.cmd_rdy          = cmd_rdy_c;
  assign bus.clr_cmd_rdy_UART = clr_uart_c;
  assign bus.resp             = resp_q;
  assign mv_indx              = mv_indx_q;

endmodule
